// File: rtl/poker_dealer.sv
// Sequential five-card dealer: draws distinct valid cards from a 16-bit LFSR
// (or an injected test card) and presents them as one hand over valid/ready.
module poker_dealer #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter logic [7:0]  MAX_REJ = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        inj_en,
    input  logic [5:0]  inj_card,
    output logic        busy,
    output logic        hand_valid,
    input  logic        hand_ready,
    output logic [5:0]  o0,
    output logic [5:0]  o1,
    output logic [5:0]  o2,
    output logic [5:0]  o3,
    output logic [5:0]  o4,
    output logic [7:0]  rej_cnt
);

    typedef enum logic [1:0] {IDLE, DRAW, PRESENT} state_t;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [2:0]  r_count;
    logic [5:0]  r_slot [0:4];
    logic [7:0]  r_rej;
    logic        r_busy;
    logic        r_valid;

    logic [5:0]  w_cand;
    logic        w_rank_ok;
    logic        w_dup;
    logic        w_accept;
    logic        w_feedback;

    // Only slots already filled this hand take part in the duplicate check.
    always_comb begin
        w_cand     = inj_en ? inj_card : {r_lfsr[5:4], r_lfsr[11:8]};
        w_rank_ok  = (w_cand[3:0] >= 4'd1) && (w_cand[3:0] <= 4'd13);
        w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
        w_dup      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ((3'(i) < r_count) && (r_slot[i] == w_cand)) begin
                w_dup = 1'b1;
            end
        end
        w_accept = w_rank_ok && !w_dup;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_lfsr  <= SEED;
            r_count <= 3'd0;
            r_rej   <= 8'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_slot[i] <= 6'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (seed_load) begin
                        r_lfsr <= (seed == 16'd0) ? SEED : seed;
                    end
                    if (start) begin
                        r_state <= DRAW;
                        r_busy  <= 1'b1;
                        r_count <= 3'd0;
                        r_rej   <= 8'd0;
                        for (int i = 0; i < 5; i++) begin
                            r_slot[i] <= 6'd0;
                        end
                    end
                end
                DRAW: begin
                    r_lfsr <= {r_lfsr[14:0], w_feedback};
                    if (w_accept) begin
                        r_slot[r_count] <= w_cand;
                        r_count         <= r_count + 3'd1;
                        if (r_count == 3'd4) begin
                            r_state <= PRESENT;
                        end
                    end else if (r_rej != MAX_REJ) begin
                        r_rej <= r_rej + 8'd1;
                    end
                end
                PRESENT: begin
                    // First PRESENT cycle raises valid; ready only counts once valid is seen.
                    if (r_valid && hand_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign hand_valid = r_valid;
    assign o0         = r_slot[0];
    assign o1         = r_slot[1];
    assign o2         = r_slot[2];
    assign o3         = r_slot[3];
    assign o4         = r_slot[4];
    assign rej_cnt    = r_rej;

endmodule
